// File: rtl/mult_datapath_pkg.sv
// Shared types and constants for the mult_datapath block.
// Optional cycle counter is enabled with the MULT_DP_CYCLE_COUNT_EN macro.
package mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int WIDTH_DEF = 3;

    // ALU operand-X select (MUX_IN2_CONT).
    localparam logic SEL_R1   = 1'b0;
    localparam logic SEL_R2   = 1'b1;

    // ALU operand-Y select (MUX_IN1_CONT).
    localparam logic SEL_A    = 1'b0;
    localparam logic SEL_ZERO = 1'b1;

    // Saturation ceiling of the optional cycle counter.
    localparam logic [7:0] CYCLE_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_INC  = 2'd1,
        ALU_ZERO = 2'd2,
        ALU_PASS = 2'd3
    } alu_op_e;

    // Decode the raw controller ALU strobe into the enumerated op.
    function automatic alu_op_e to_alu_op(input logic [1:0] raw);
        return alu_op_e'(raw);
    endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// Controller <-> datapath strobe and result bus for mult_datapath.
// master: the MULT_FSM controller side; slave: the datapath.
interface mult_datapath_if #(
    parameter int WIDTH = mult_pkg::WIDTH_DEF
);

    logic [WIDTH-1:0]   A_IN;
    logic [WIDTH-1:0]   B_IN;
    logic               MUX_IN1_CONT;
    logic               MUX_IN2_CONT;
    logic [1:0]         ALU_CONT;
    logic               LOAD_A_REG;
    logic               LOAD_B_REG;
    logic               LOAD_R1_REG;
    logic               LOAD_R2_REG;
    logic               LOAD_F_REG;
    logic               R2_LT_B_1;
    logic [2*WIDTH-1:0] PRODUCT;
    logic               PRODUCT_VALID;

    modport master (
        output A_IN, B_IN, MUX_IN1_CONT, MUX_IN2_CONT, ALU_CONT,
               LOAD_A_REG, LOAD_B_REG, LOAD_R1_REG, LOAD_R2_REG, LOAD_F_REG,
        input  R2_LT_B_1, PRODUCT, PRODUCT_VALID
    );

    modport slave (
        input  A_IN, B_IN, MUX_IN1_CONT, MUX_IN2_CONT, ALU_CONT,
               LOAD_A_REG, LOAD_B_REG, LOAD_R1_REG, LOAD_R2_REG, LOAD_F_REG,
        output R2_LT_B_1, PRODUCT, PRODUCT_VALID
    );

endinterface

// File: rtl/mult_datapath_alu.sv
// mult_alu: combinational ALU of the mult_datapath, product width wide.
module mult_alu
    import mult_pkg::*;
#(
    parameter int PW = 2 * WIDTH_DEF
) (
    input  alu_op_e       op,
    input  logic [PW-1:0] x,
    input  logic [PW-1:0] y,
    output logic [PW-1:0] res
);

    // Select the ALU result; addition wraps modulo 2^PW.
    always_comb begin
        res = x;
        case (op)
            ALU_ADD:  res = x + y;
            ALU_INC:  res = x + PW'(1);
            ALU_ZERO: res = '0;
            ALU_PASS: res = x;
            default:  res = x;
        endcase
    end

endmodule

// File: rtl/mult_datapath.sv
// mult_datapath: repeated-addition multiplier datapath driven by MULT_FSM.
// Holds A/B operands, accumulator R1, counter R2 and result F.
// Define MULT_DP_CYCLE_COUNT_EN to add the CYCLE_COUNT output.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic          SYS_CLOCK,
    input  logic          SYS_RESET,
    mult_datapath_if.slave dp
`ifdef MULT_DP_CYCLE_COUNT_EN
    ,
    output logic [7:0]    CYCLE_COUNT
`endif
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    r1_q, r1_d;
    logic [WIDTH-1:0] r2_q, r2_d;
    logic [PW-1:0]    f_q, f_d;
    logic             valid_q, valid_d;

    logic [PW-1:0]    alu_x;
    logic [PW-1:0]    alu_y;
    logic [PW-1:0]    alu_res;
    logic [WIDTH:0]   r2_plus1;

    // Operand muxes in front of the ALU; R2 and A zero-extend to product width.
    always_comb begin
        alu_x = (dp.MUX_IN2_CONT == SEL_R2) ? {{WIDTH{1'b0}}, r2_q} : r1_q;
        alu_y = (dp.MUX_IN1_CONT == SEL_ZERO) ? '0 : {{WIDTH{1'b0}}, a_q};
    end

    mult_alu #(.PW(PW)) u_alu (
        .op  (to_alu_op(dp.ALU_CONT)),
        .x   (alu_x),
        .y   (alu_y),
        .res (alu_res)
    );

    // Independent load enables, all computed from pre-edge register values.
    always_comb begin
        a_d     = dp.LOAD_A_REG  ? dp.A_IN             : a_q;
        b_d     = dp.LOAD_B_REG  ? dp.B_IN             : b_q;
        r1_d    = dp.LOAD_R1_REG ? alu_res             : r1_q;
        r2_d    = dp.LOAD_R2_REG ? alu_res[WIDTH-1:0]  : r2_q;
        f_d     = dp.LOAD_F_REG  ? r1_q                : f_q;
        // A fresh operand load invalidates F, but an F load in the same cycle wins.
        valid_d = valid_q;
        if (dp.LOAD_A_REG) valid_d = 1'b0;
        if (dp.LOAD_F_REG) valid_d = 1'b1;
    end

    // Datapath register bank with synchronous reset overriding every strobe.
    always_ff @(posedge SYS_CLOCK) begin
        if (SYS_RESET) begin
            a_q     <= '0;
            b_q     <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            f_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            f_q     <= f_d;
            valid_q <= valid_d;
        end
    end

    // Loop-status compare at WIDTH+1 bits so R2=2^WIDTH-1 cannot wrap to 0.
    always_comb begin
        r2_plus1     = {1'b0, r2_q} + (WIDTH + 1)'(1);
        dp.R2_LT_B_1 = (r2_plus1 < {1'b0, b_q});
    end

    assign dp.PRODUCT       = f_q;
    assign dp.PRODUCT_VALID = valid_q;

`ifdef MULT_DP_CYCLE_COUNT_EN
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cycle_count_q, cycle_count_d;

    // Count cycles of an operation in flight; latch the count when F loads.
    always_comb begin
        cnt_d = cnt_q;
        if (dp.LOAD_A_REG) begin
            cnt_d = '0;
        end else if (!valid_q && (cnt_q != CYCLE_MAX)) begin
            cnt_d = cnt_q + 8'd1;
        end
        cycle_count_d = dp.LOAD_F_REG ? cnt_q : cycle_count_q;
    end

    // Cycle counter registers.
    always_ff @(posedge SYS_CLOCK) begin
        if (SYS_RESET) begin
            cnt_q         <= '0;
            cycle_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign CYCLE_COUNT = cycle_count_q;
`endif

endmodule
